// File: rtl/demdongbo_meter.sv
`default_nettype none
// ============================================================================
// Module      : demdongbo_meter
// Description : Period / high-time meter for a slow asynchronous square wave.
// Revision    : 1.0 - initial release
// ============================================================================
module demdongbo_meter #(
  parameter int N   = 26,
  parameter int TMO = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         valid,
  output logic         timeout
);

  localparam logic [0:0]   S_IDLE = 1'b0;
  localparam logic [0:0]   S_MEAS = 1'b1;
  localparam logic [N-1:0] C_ONE  = N'(1);
  localparam logic [N-1:0] C_MAX  = '1;
  localparam logic [N-1:0] C_TMO  = N'(TMO);

  logic         r_s1, r_s2, r_s3;
  logic [0:0]   r_state;
  logic [N-1:0] r_cnt;
  logic         r_fall_seen;
  logic [N-1:0] r_hi_tmp;
  logic [N-1:0] r_period;
  logic [N-1:0] r_high_time;
  logic         r_valid;
  logic         r_timeout;

  logic w_rise;
  logic w_fall;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fall_seen <= 1'b0;
      r_hi_tmp    <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_s1    <= sig_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;

      // At a rise cycle r_cnt holds the cycles since the previous rise.
      if (w_rise) begin
        r_cnt <= C_ONE;
      end else if (r_cnt != C_MAX) begin
        r_cnt <= r_cnt + C_ONE;
      end

      if (w_rise) begin
        r_fall_seen <= 1'b0;
      end else if (w_fall && (r_state == S_MEAS)) begin
        r_hi_tmp    <= r_cnt;
        r_fall_seen <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_MEAS;
          end
        end
        S_MEAS: begin
          // A rise coinciding with the timeout count still completes the period.
          if (w_rise) begin
            if (r_fall_seen) begin
              r_period    <= r_cnt;
              r_high_time <= r_hi_tmp;
              r_valid     <= 1'b1;
              r_timeout   <= 1'b0;
            end
          end else if (r_cnt == C_TMO) begin
            r_state     <= S_IDLE;
            r_timeout   <= 1'b1;
            r_fall_seen <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_demdongbo_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_demdongbo_meter
// Description : Self-checking bench for demdongbo_meter (scoreboard + table).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demdongbo_meter;

  localparam int N = 26;

  logic         clk = 1'b0;
  logic         reset_a, reset_b;
  logic         sig_a, sig_b;
  logic [N-1:0] period_a, high_a, period_b, high_b;
  logic         valid_a, timeout_a, valid_b, timeout_b;

  demdongbo_meter #(.N(N), .TMO(200)) dut_a (
    .clk(clk), .reset(reset_a), .sig_in(sig_a),
    .period(period_a), .high_time(high_a), .valid(valid_a), .timeout(timeout_a)
  );

  demdongbo_meter #(.N(N), .TMO(51)) dut_b (
    .clk(clk), .reset(reset_b), .sig_in(sig_b),
    .period(period_b), .high_time(high_b), .valid(valid_b), .timeout(timeout_b)
  );

  always #5 clk = ~clk;

  typedef struct {int p; int h; int cyc;} exp_t;
  typedef struct {int hi; int lo; int reps; int exp_period; int exp_high;} vec_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  int   hold_p = 0;
  int   hold_h = 0;
  bit   prev_ok = 1'b0;
  exp_t prev;
  int   last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Scoreboard consumer for dut_a: every valid pops one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_a) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("period", int'(period_a), e.p);
          check("high_time", int'(high_a), e.h);
          check("valid_cycle", cyc, e.cyc);
          check("timeout_at_valid", int'(timeout_a), 0);
          hold_p = e.p;
          hold_h = e.h;
        end
      end else begin
        check("period_hold", int'(period_a), hold_p);
        check("high_hold", int'(high_a), hold_h);
      end
    end
  end

  // One full period: high for hi cycles then low for lo cycles; the rise at
  // its start completes the previously driven period.
  task automatic drive_period(input int hi, input int lo, input int ep, input int eh);
    for (int i = 0; i < hi + lo; i++) begin
      @(posedge clk);
      #1;
      sig_a = (i < hi);
      if (i == 0) begin
        if (prev_ok) begin
          exp_t e;
          e = prev;
          e.cyc = cyc + 3;
          q.push_back(e);
        end
        prev.p    = ep;
        prev.h    = eh;
        prev_ok   = 1'b1;
        last_rise = cyc;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vt[5];
  int   nvb;

  initial begin
    vt[0] = '{hi: 26, lo: 25, reps: 4, exp_period: 51, exp_high: 26};
    vt[1] = '{hi: 1,  lo: 1,  reps: 6, exp_period: 2,  exp_high: 1};
    vt[2] = '{hi: 10, lo: 41, reps: 3, exp_period: 51, exp_high: 10};
    vt[3] = '{hi: 3,  lo: 5,  reps: 3, exp_period: 8,  exp_high: 3};
    vt[4] = '{hi: 26, lo: 25, reps: 2, exp_period: 51, exp_high: 26};

    reset_a = 1'b1;
    reset_b = 1'b1;
    sig_a   = 1'b0;
    sig_b   = 1'b0;
    idle_cycles(2);
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    check("reset_period", int'(period_a), 0);
    check("reset_high", int'(high_a), 0);
    check("reset_valid", int'(valid_a), 0);
    check("reset_timeout", int'(timeout_a), 0);
    mon_en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < vt[v].reps; r++) begin
        drive_period(vt[v].hi, vt[v].lo, vt[v].exp_period, vt[v].exp_high);
      end
    end

    // Timeout: hold low after the last rise; the pending period never closes.
    prev_ok = 1'b0;
    while (cyc < last_rise + 202) @(negedge clk);
    check("timeout_before", int'(timeout_a), 0);
    @(negedge clk);
    check("timeout_after", int'(timeout_a), 1);
    drive_period(26, 25, 51, 26);
    @(negedge clk);
    check("timeout_sticky_rearm", int'(timeout_a), 1);
    drive_period(26, 25, 51, 26);
    drive_period(26, 25, 51, 26);
    @(negedge clk);
    check("timeout_cleared", int'(timeout_a), 0);

    // Reset in the low phase of a period discards the partial measurement.
    drive_period(26, 10, 0, 0);
    reset_a = 1'b1;
    @(posedge clk);
    #1;
    reset_a = 1'b0;
    prev_ok = 1'b0;
    hold_p  = 0;
    hold_h  = 0;
    @(negedge clk);
    check("midreset_period", int'(period_a), 0);
    check("midreset_high", int'(high_a), 0);
    check("midreset_valid", int'(valid_a), 0);
    check("midreset_timeout", int'(timeout_a), 0);
    idle_cycles(15);
    for (int r = 0; r < 3; r++) drive_period(26, 25, 51, 26);

    prev_ok = 1'b0;
    idle_cycles(6);
    check("queue_drained", q.size(), 0);

    // TMO equal to the period: rise and timeout coincide on every period.
    nvb = 0;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 51; i++) begin
        @(posedge clk);
        #1;
        sig_b = (i < 26);
        @(negedge clk);
        check("b_timeout", int'(timeout_b), 0);
        if (valid_b) begin
          nvb++;
          check("b_period", int'(period_b), 51);
          check("b_high", int'(high_b), 26);
        end
      end
    end
    check("b_valid_count", nvb, 5);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
